// File: rtl/control_sequencer.sv
// -----------------------------------------------------------------------------
// control_sequencer
//
// Hardwired Moore control unit for the phase-3 datapath. Walks every
// instruction through fetch (T0-T2) and the opcode-specific execute steps
// (T3-T7), emitting one set of datapath strobes per cycle.
//
// Ports
//   clk         rising-edge system clock
//   clr         asynchronous, active-high reset (forces RST, all strobes low)
//   IR          instruction register; opcode = IR[31:27]
//   stop        halt request, honoured only on the edge that ends an
//               instruction
//   PCout..IRin fetch / memory strobes
//   Gra..RAMwrite execute strobes
//   ALUControl  one-hot ALU operation (bit0 ADD, bit1 SUB, bit2 AND, bit3 OR)
//   run         high in every state except HALT
//
// Outputs are a pure function of the state register and IR[31:27].
// -----------------------------------------------------------------------------
module control_sequencer #(
    parameter int ALU_W = 12
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [31:0]      IR,
    input  logic             stop,

    output logic             PCout,
    output logic             MARin,
    output logic             IncPC,
    output logic             Zin,
    output logic             PCin,
    output logic             Zlowout,
    output logic             RAMread,
    output logic             MDRRead,
    output logic             MDRin,
    output logic             MDRout,
    output logic             IRin,

    output logic             Gra,
    output logic             Grb,
    output logic             Grc,
    output logic             Rin_in,
    output logic             Rout_in,
    output logic             BAout,
    output logic             Yin,
    output logic             Cout,
    output logic             HIout,
    output logic             LOout,
    output logic             InPortout,
    output logic             OutPortIn,
    output logic             RAMwrite,

    output logic [ALU_W-1:0] ALUControl,
    output logic             run
);

    typedef enum logic [3:0] {
        S_RST,
        S_T0,
        S_T1,
        S_T2,
        S_T3,
        S_T4,
        S_T5,
        S_T6,
        S_T7,
        S_HALT
    } state_t;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_IN   = 5'b10110;
    localparam logic [4:0] OP_OUT  = 5'b10111;
    localparam logic [4:0] OP_MFHI = 5'b11000;
    localparam logic [4:0] OP_MFLO = 5'b11001;
    localparam logic [4:0] OP_HALT = 5'b11011;

    localparam logic [ALU_W-1:0] ALU_ADD = {{(ALU_W-4){1'b0}}, 4'b0001};
    localparam logic [ALU_W-1:0] ALU_SUB = {{(ALU_W-4){1'b0}}, 4'b0010};
    localparam logic [ALU_W-1:0] ALU_AND = {{(ALU_W-4){1'b0}}, 4'b0100};
    localparam logic [ALU_W-1:0] ALU_OR  = {{(ALU_W-4){1'b0}}, 4'b1000};

    state_t          state;
    state_t          next_state;
    state_t          boundary_state;
    logic [4:0]      opcode;
    logic            is_alu;
    logic            is_ldi;
    logic            is_ld;
    logic            is_st;
    logic            uses_ea;     // ldi, ld and st share the Rb + C address step
    logic [ALU_W-1:0] alu_op;

    // Only the opcode field steers the sequence; operand fields belong to
    // the datapath.
    logic            unused_ir_fields;
    assign unused_ir_fields = ^IR[26:0];

    assign opcode  = IR[31:27];
    assign is_alu  = (opcode == OP_ADD) || (opcode == OP_SUB) ||
                     (opcode == OP_AND) || (opcode == OP_OR);
    assign is_ldi  = (opcode == OP_LDI);
    assign is_ld   = (opcode == OP_LD);
    assign is_st   = (opcode == OP_ST);
    assign uses_ea = is_ldi || is_ld || is_st;

    // Where the sequencer goes after the final step of any instruction.
    assign boundary_state = stop ? S_HALT : S_T0;

    always_comb begin
        alu_op = '0;
        case (opcode)
            OP_ADD:  alu_op = ALU_ADD;
            OP_SUB:  alu_op = ALU_SUB;
            OP_AND:  alu_op = ALU_AND;
            OP_OR:   alu_op = ALU_OR;
            default: alu_op = '0;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its inputs from before the edge.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state <= S_RST;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // through the case statement can leave a latch behind.
        next_state = state;
        PCout      = 1'b0;
        MARin      = 1'b0;
        IncPC      = 1'b0;
        Zin        = 1'b0;
        PCin       = 1'b0;
        Zlowout    = 1'b0;
        RAMread    = 1'b0;
        MDRRead    = 1'b0;
        MDRin      = 1'b0;
        MDRout     = 1'b0;
        IRin       = 1'b0;
        Gra        = 1'b0;
        Grb        = 1'b0;
        Grc        = 1'b0;
        Rin_in     = 1'b0;
        Rout_in    = 1'b0;
        BAout      = 1'b0;
        Yin        = 1'b0;
        Cout       = 1'b0;
        HIout      = 1'b0;
        LOout      = 1'b0;
        InPortout  = 1'b0;
        OutPortIn  = 1'b0;
        RAMwrite   = 1'b0;
        ALUControl = '0;
        run        = 1'b1;

        case (state)
            S_RST: begin
                next_state = S_T0;
            end

            S_T0: begin
                PCout      = 1'b1;
                MARin      = 1'b1;
                IncPC      = 1'b1;
                Zin        = 1'b1;
                next_state = S_T1;
            end

            S_T1: begin
                Zlowout    = 1'b1;
                PCin       = 1'b1;
                RAMread    = 1'b1;
                MDRRead    = 1'b1;
                MDRin      = 1'b1;
                next_state = S_T2;
            end

            S_T2: begin
                MDRout     = 1'b1;
                IRin       = 1'b1;
                next_state = S_T3;
            end

            S_T3: begin
                if (is_alu) begin
                    Grb     = 1'b1;
                    Rout_in = 1'b1;
                    Yin     = 1'b1;
                end else if (uses_ea) begin
                    Grb     = 1'b1;
                    BAout   = 1'b1;
                    Yin     = 1'b1;
                end else begin
                    case (opcode)
                        OP_MFHI: begin
                            HIout  = 1'b1;
                            Gra    = 1'b1;
                            Rin_in = 1'b1;
                        end
                        OP_MFLO: begin
                            LOout  = 1'b1;
                            Gra    = 1'b1;
                            Rin_in = 1'b1;
                        end
                        OP_IN: begin
                            InPortout = 1'b1;
                            Gra       = 1'b1;
                            Rin_in    = 1'b1;
                        end
                        OP_OUT: begin
                            Gra       = 1'b1;
                            Rout_in   = 1'b1;
                            OutPortIn = 1'b1;
                        end
                        default: begin
                            // nop, halt and undefined opcodes drive nothing.
                        end
                    endcase
                end

                if (is_alu || uses_ea) begin
                    next_state = S_T4;
                end else if (opcode == OP_HALT) begin
                    next_state = S_HALT;
                end else begin
                    next_state = boundary_state;
                end
            end

            S_T4: begin
                if (is_alu) begin
                    Grc        = 1'b1;
                    Rout_in    = 1'b1;
                    ALUControl = alu_op;
                    Zin        = 1'b1;
                end else if (uses_ea) begin
                    Cout       = 1'b1;
                    ALUControl = ALU_ADD;
                    Zin        = 1'b1;
                end
                next_state = S_T5;
            end

            S_T5: begin
                Zlowout = 1'b1;
                if (is_ld || is_st) begin
                    // Effective address goes to MAR; the memory phase follows.
                    MARin      = 1'b1;
                    next_state = S_T6;
                end else begin
                    Gra        = 1'b1;
                    Rin_in     = 1'b1;
                    next_state = boundary_state;
                end
            end

            S_T6: begin
                if (is_ld) begin
                    RAMread = 1'b1;
                    MDRRead = 1'b1;
                    MDRin   = 1'b1;
                end else if (is_st) begin
                    // MDR loads from the bus (Ra), not from memory.
                    Gra     = 1'b1;
                    Rout_in = 1'b1;
                    MDRin   = 1'b1;
                end
                next_state = S_T7;
            end

            S_T7: begin
                if (is_ld) begin
                    MDRout = 1'b1;
                    Gra    = 1'b1;
                    Rin_in = 1'b1;
                end else if (is_st) begin
                    RAMwrite = 1'b1;
                end
                next_state = boundary_state;
            end

            S_HALT: begin
                run        = 1'b0;
                next_state = S_HALT;
            end

            default: begin
                next_state = S_RST;
            end
        endcase
    end

endmodule
